// File: rtl/pc_sequencer_if.sv
// ============================================================================
// pc_sequencer_if : bundle between the core datapath and the next-PC sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pc_sequencer_if;
  logic [31:0] pc_cur;
  logic        stall_ext;
  logic        br_taken;
  logic [15:0] br_imm;
  logic        jmp;
  logic [25:0] jmp_index;
  logic        jr;
  logic [31:0] rs_val;
  logic        exc_req;
  logic [4:0]  exc_cause_in;
  logic        eret;
  logic [31:0] epc_in;
  logic        mc_start;
  logic        mc_done;
  logic        pc_we;
  logic [31:0] pc_next;
  logic        stall;
  logic        exc_valid;
  logic [4:0]  exc_cause_out;
  logic [31:0] epc_out;
  logic        mc_timeout;

  modport master (
    output pc_cur, stall_ext, br_taken, br_imm, jmp, jmp_index, jr, rs_val,
           exc_req, exc_cause_in, eret, epc_in, mc_start, mc_done,
    input  pc_we, pc_next, stall, exc_valid, exc_cause_out, epc_out, mc_timeout
  );

  modport slave (
    input  pc_cur, stall_ext, br_taken, br_imm, jmp, jmp_index, jr, rs_val,
           exc_req, exc_cause_in, eret, epc_in, mc_start, mc_done,
    output pc_we, pc_next, stall, exc_valid, exc_cause_out, epc_out, mc_timeout
  );
endinterface

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer : next-PC select for the single-cycle MIPS core, with a
//                mult/div freeze guarded by a watchdog counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h00400000,
  parameter logic [31:0] EXC_VECTOR = 32'h00400004,
  parameter int          MC_TIMEOUT = 64,
  parameter int          CNT_W      = 7
) (
  input  wire logic      clk,
  input  wire logic      rst,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_WAIT_MC = 2'd1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mc_timeout_q, mc_timeout_d;

  logic [31:0]        pc4;
  logic [31:0]        br_tgt;
  logic [31:0]        j_tgt;
  logic               cnt_last;

  logic               we;
  logic [31:0]        nxt;
  logic               stl;
  logic               ev;
  logic [4:0]         cause;
  logic [31:0]        epc;

  always_comb begin
    pc4      = bus.pc_cur + 32'd4;
    br_tgt   = pc4 + {{14{bus.br_imm[15]}}, bus.br_imm, 2'b00};
    j_tgt    = {pc4[31:28], bus.jmp_index, 2'b00};
    cnt_last = (cnt_q == CNT_W'(MC_TIMEOUT - 1));
  end

  // The value on pc_next is a don't-care while pc_we is low; RESET_PC keeps it a known constant.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mc_timeout_d = 1'b0;
    we           = 1'b0;
    nxt          = RESET_PC;
    stl          = 1'b1;
    ev           = 1'b0;
    cause        = 5'd0;
    epc          = 32'd0;

    case (state_q)
      S_RUN: begin
        if (!bus.stall_ext) begin
          we  = 1'b1;
          stl = 1'b0;
          if (bus.exc_req) begin
            nxt   = EXC_VECTOR;
            ev    = 1'b1;
            cause = bus.exc_cause_in;
            epc   = bus.pc_cur;
          end else if (bus.eret) begin
            nxt = bus.epc_in;
          end else if (bus.mc_start) begin
            we      = 1'b0;
            stl     = 1'b1;
            state_d = S_WAIT_MC;
            cnt_d   = '0;
          end else if (bus.jr) begin
            nxt = bus.rs_val;
          end else if (bus.jmp) begin
            nxt = j_tgt;
          end else if (bus.br_taken) begin
            nxt = br_tgt;
          end else begin
            nxt = pc4;
          end
        end
      end

      S_WAIT_MC: begin
        cnt_d = cnt_q + CNT_W'(1);
        // mc_done wins over the watchdog and over stall_ext.
        if (bus.mc_done || cnt_last) begin
          we           = 1'b1;
          nxt          = pc4;
          stl          = 1'b0;
          state_d      = S_RUN;
          cnt_d        = '0;
          mc_timeout_d = !bus.mc_done;
        end
      end

      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_RUN;
      cnt_q        <= '0;
      mc_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mc_timeout_q <= mc_timeout_d;
    end
  end

  // Combinational outputs are held at zero for the whole time reset is asserted.
  always_comb begin
    bus.pc_we         = rst & we;
    bus.pc_next       = rst ? nxt : 32'd0;
    bus.stall         = rst & stl;
    bus.exc_valid     = rst & ev;
    bus.exc_cause_out = rst ? cause : 5'd0;
    bus.epc_out       = rst ? epc : 32'd0;
    bus.mc_timeout    = mc_timeout_q;
  end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC controller for the single-cycle MIPS core; drives the write-enable and data inputs of the program counter register.
- Selects the next fetch address from:
  - sequential advance;
  - branch, jump and jr targets;
  - exception entry and eret.
- Freezes the PC while a multi-cycle unit (mult/div) is busy, with a watchdog so a missing mc_done cannot hang the core.
- No branch delay slot.

Parameters:
- RESET_PC, 32'h00400000, fetch address the PC register holds after reset; informational, not driven by this block.
- EXC_VECTOR, 32'h00400004, exception entry address.
- MC_TIMEOUT, 64, maximum WAIT_MC cycles before a forced advance; must be ≥2.
- CNT_W, 7, counter width; must satisfy 2^CNT_W > MC_TIMEOUT.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- pc_cur  in  32  current PC value.
- stall_ext  in  1  external hold; PC not written while high.
- br_taken  in  1  conditional branch resolved taken.
- br_imm  in  16  branch offset field.
- jmp  in  1  j/jal.
- jmp_index  in  26  instr_index field.
- jr  in  1  jr/jalr.
- rs_val  in  32  register rs value.
- exc_req  in  1  syscall/break/teq trap this cycle.
- exc_cause_in  in  5  cause code for exc_req.
- eret  in  1  eret instruction.
- epc_in  in  32  EPC from CP0.
- mc_start  in  1  current instruction launches mult/div.
- mc_done  in  1  multi-cycle unit result ready.
- pc_we  out  1  PC write enable.
- pc_next  out  32  PC write data.
- stall  out  1  core must hold all architectural writes.
- exc_valid  out  1  CP0 exception strobe.
- exc_cause_out  out  5  cause to CP0.
- epc_out  out  32  EPC value to CP0.
- mc_timeout  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Arithmetic:
  - pc4 = pc_cur+4, 32-bit wrap.
  - br_tgt = pc4 + (sign-extended br_imm << 2), 32-bit wrap.
  - j_tgt = {pc4[31:28], jmp_index, 2'b00}.
- States: RUN, WAIT_MC. A 2-bit state register is permitted, with an unused encoding returning to RUN.
- Reset (rst=0, asynchronous):
  - state=RUN, cnt=0, mc_timeout=0.
  - All combinational outputs forced to 0 while rst=0.
- RUN, stall_ext=1: pc_we=0, stall=1, exc_valid=0; state unchanged.
- RUN, stall_ext=0: pc_we=1, stall=0. pc_next is chosen by fixed priority:
  1. exc_req → EXC_VECTOR; also exc_valid=1, exc_cause_out=exc_cause_in, epc_out=pc_cur.
  2. eret → epc_in.
  3. mc_start → pc_we=0, stall=1, next state WAIT_MC, cnt←0.
  4. jr → rs_val.
  5. jmp → j_tgt.
  6. br_taken → br_tgt.
  7. otherwise pc4.
- Exception overrides mc_start in the same cycle; WAIT_MC is not entered.
- exc_valid, exc_cause_out and epc_out are combinational and valid only in the cycle pc_we=1 with exc_req. Otherwise exc_cause_out=0 and epc_out=0.
- WAIT_MC:
  - pc_we=0, stall=1; cnt increments each cycle.
  - exc_req, eret, jr, jmp and br_taken are ignored.
- WAIT_MC with mc_done=1: pc_we=1, pc_next=pc4, stall=0; next state RUN.
  - Completion takes effect even if stall_ext=1 and ignores the watchdog in that cycle.
- WAIT_MC with mc_done=0 and cnt==MC_TIMEOUT-1: same forced advance as mc_done (pc_we=1, pc_next=pc4, stall=0, next state RUN). mc_timeout is asserted as a registered pulse in the following cycle.
- mc_done while in RUN is ignored.
- Minimum WAIT_MC residency is 1 cycle, when mc_done arrives in the first WAIT_MC cycle.
- Reset asserted during WAIT_MC aborts to RUN with cnt=0. No pc_we is issued until after reset deasserts.
- pc_next bit 22 is passed unmodified.

Test Plan:
- Reset then sequential: release rst with pc_cur=32'h00400000 and no controls → pc_we=1, pc_next=32'h00400004. Assert rst=0 mid-cycle → pc_we drops to 0 immediately.
- Branch/jump:
  - pc_cur=32'h00400010, br_taken=1, br_imm=16'hFFFC → pc_next=32'h00400004.
  - jmp=1 with br_taken=1, jmp_index=26'h0100008 → pc_next=32'h00400020 (jump wins).
  - jr=1 with jmp=1, rs_val=32'h00400100 → pc_next=32'h00400100.
- Exception/eret:
  - exc_req=1, exc_cause_in=5'd8, mc_start=1, pc_cur=32'h00400030 → pc_we=1, pc_next=32'h00400004, exc_valid=1, epc_out=32'h00400030; state stays RUN.
  - eret=1, epc_in=32'h00400034 → pc_next=32'h00400034.
- Multi-cycle:
  - mc_start at pc_cur=32'h00400040 → pc_we=0, stall=1 for 5 cycles.
  - mc_done in the 5th WAIT_MC cycle → pc_we=1, pc_next=32'h00400044, then RUN.
  - jmp=1 asserted during wait → no effect.
- Watchdog: MC_TIMEOUT=8, mc_start, mc_done never asserted → forced advance in the 8th WAIT_MC cycle, mc_timeout high for exactly one cycle after.
- stall_ext: stall_ext=1 in RUN for 3 cycles → pc_we=0, stall=1. stall_ext=1 in WAIT_MC coinciding with mc_done → completion still advances PC.
